prog_loader: RTL
================

Name: prog_loader

Overview:
- Serial program loader that sits directly upstream of the 17-bit word storage slices in the 6-bit CPU.
- Receives instruction words one bit per valid clock, MSB first, and assembles each into a 17-bit word.
- Drives the shared write-data bus plus a one-hot write select, one select line per storage word.
- Writes words to consecutive addresses starting at 0 until the requested count is loaded.

Parameters:
- WORD_W, 17, width of one stored word (matches storage slice width).
- DEPTH, 16, number of storage words; width of the one-hot write select.
- ADDR_W, 4, width of address and length fields; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled in IDLE only.
- len  input  ADDR_W+1  number of words to load; sampled on start. Valid range 0..DEPTH.
- ser_in  input  1  serial data bit, MSB first.
- ser_valid  input  1  ser_in is valid this cycle.
- wd  output  WORD_W  write data to storage slices.
- ws  output  DEPTH  one-hot write select; all zero except during a WRITE cycle.
- addr  output  ADDR_W  index of the word currently being assembled or written.
- busy  output  1  high in SHIFT and WRITE.
- done  output  1  one-cycle pulse when the load completes.
- overrun  output  1  sticky flag: a serial bit was dropped. Cleared on start or rst.

Behaviour:
- Reset (async, immediate) forces:
  - state=IDLE
  - wd=0, ws=0, addr=0, busy=0, done=0, overrun=0
  - internal shift register=0, bit counter=0, latched length=0
- Asserting rst mid-load aborts the load. No ws pulse may occur after rst rises.
- States: IDLE, SHIFT, WRITE, DONE.
- IDLE:
  - start=1, len=0 -> DONE. No write occurs.
  - start=1, len>DEPTH -> clamp to DEPTH.
  - start=1, len valid -> latch len, addr=0, bitcnt=0, clear overrun, go to SHIFT.
  - ser_valid in IDLE is ignored and does not set overrun.
- SHIFT:
  - Each cycle with ser_valid=1: shreg <= {shreg[WORD_W-2:0], ser_in}, bitcnt++.
  - On the cycle the WORD_W-th bit is accepted (bitcnt==WORD_W-1 and ser_valid):
    - wd <= completed word {shreg[WORD_W-2:0], ser_in}
    - bitcnt <= 0
    - next state WRITE
  - Cycles with ser_valid=0 stall without changing state or data.
- WRITE (exactly one cycle):
  - ws = one-hot (1<<addr), wd stable the whole cycle. The storage slices capture at the end-of-cycle edge.
  - If addr==len-1: next state DONE, addr unchanged.
  - Otherwise: addr++, next state SHIFT.
  - ser_valid=1 here drops the bit and sets overrun=1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. ser_valid here is ignored.
- Output timing:
  - ws is a registered output and is never asserted outside WRITE.
  - wd changes only on the word-complete edge and holds its value through WRITE and afterwards, until the next word completes.
  - busy = (state==SHIFT || state==WRITE), registered.
- start while not in IDLE is ignored.
- Latency: last bit of a word accepted at edge N -> ws asserted in cycle N+1.
  - Last word's WRITE -> done asserted the following cycle.
  - Minimum load time: len*(WORD_W+1) + 2 cycles from start.
- addr never exceeds DEPTH-1. There is no wrap; the clamp guarantees this.

Test Plan:
- Reset with no load:
  - Stimulus: rst pulse, then start, len=1, serial word 17'h1A5C3 sent MSB first with ser_valid continuous.
  - Required: wd=17'h1A5C3 and ws=16'h0001 for exactly one cycle, 18 cycles after start. done pulses the next cycle. busy low afterwards.
- Multi-word load:
  - Stimulus: len=3, words 17'h00001, 17'h10000, 17'h1FFFF, with ser_valid toggling 1/0 every cycle.
  - Required: ws pulses 0x0001, 0x0002, 0x0004 in order, each with the matching wd. addr ends at 2. Exactly one done.
- Zero length:
  - Stimulus: start with len=0.
  - Required: done one cycle after start, ws never nonzero, busy never high.
- Clamp:
  - Stimulus: len=20 with DEPTH=16, 16 words streamed.
  - Required: writes to ws bits 0..15 only, then done. Further ser_valid in IDLE is ignored and overrun stays 0.
- Overrun:
  - Stimulus: ser_valid held high continuously for len=2.
  - Required: the bit presented during the first WRITE cycle is dropped and overrun=1.
  - Required: the second word is formed from the following 17 bits, and overrun stays 1 until the next start.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between clock edges) after 9 bits of word 0.
  - Required: all outputs 0 immediately, no ws pulse.
  - Required: a subsequent start with len=1 loads a fresh word correctly.

Source files
------------

// File: rtl/prog_loader.sv
// Serial program loader: assembles MSB-first serial bits into WORD_W-bit words and
// writes them to consecutive storage slices through a one-hot write select.
module prog_loader #(
  parameter int WORD_W = 17,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [WORD_W-1:0] wd,
  output logic [DEPTH-1:0]  ws,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic [WORD_W-1:0]  shreg_r;
  logic [CNT_W-1:0]   bitcnt_r;
  logic [ADDR_W:0]    len_r;

  function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
    return {{(DEPTH - 1){1'b0}}, 1'b1} << a;
  endfunction

  // Load sequencer; every output is registered and follows the state it enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      shreg_r  <= '0;
      bitcnt_r <= '0;
      len_r    <= '0;
      wd       <= '0;
      ws       <= '0;
      addr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      ws   <= '0;
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            overrun  <= 1'b0;
            addr     <= '0;
            bitcnt_r <= '0;
            shreg_r  <= '0;
            if (len == '0) begin
              len_r   <= '0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              // Clamping here is what keeps addr inside the storage array.
              len_r   <= (len > LEN_MAX) ? LEN_MAX : len;
              busy    <= 1'b1;
              state_r <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (ser_valid) begin
            shreg_r <= {shreg_r[WORD_W-2:0], ser_in};
            if (bitcnt_r == LAST_BIT) begin
              wd       <= {shreg_r[WORD_W-2:0], ser_in};
              bitcnt_r <= '0;
              ws       <= onehot(addr);
              state_r  <= WRITE;
            end else begin
              bitcnt_r <= bitcnt_r + CNT_ONE;
            end
          end
        end
        WRITE: begin
          // The shifter is not listening during the write cycle.
          if (ser_valid) begin
            overrun <= 1'b1;
          end
          if ({1'b0, addr} == (len_r - LEN_ONE)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            addr    <= addr + ADDR_ONE;
            state_r <= SHIFT;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
